// File: rtl/alarm_siren_ctrl_if.sv
// -----------------------------------------------------------------------------
// alarm_siren_ctrl_if
//   Groups the control inputs and the siren/LED/status outputs of the alarm
//   back end into one bundle.
//
//   Signals:
//     trigger    majority alarm flag from the sensor voter (level)
//     arm_req    one-cycle arm request
//     disarm_req one-cycle disarm request (code already validated upstream)
//     tamper     tamper level input, present only when TAMPER_EN is defined
//     siren      siren drive
//     led        status LED drive
//     alarm_mem  an alarm occurred since the last accepted arm
//     arm_fail   one-cycle pulse: arm request rejected
//     state      current FSM state code
//
//   Modports:
//     master  side that drives requests and observes status (system / bench)
//     slave   the controller itself
//
//   Optional feature macro: TAMPER_EN (adds the tamper signal).
// -----------------------------------------------------------------------------
interface alarm_siren_ctrl_if;
  logic       trigger;
  logic       arm_req;
  logic       disarm_req;
`ifdef TAMPER_EN
  logic       tamper;
`endif
  logic       siren;
  logic       led;
  logic       alarm_mem;
  logic       arm_fail;
  logic [2:0] state;

`ifdef TAMPER_EN
  modport master (
    output trigger, arm_req, disarm_req, tamper,
    input  siren, led, alarm_mem, arm_fail, state
  );

  modport slave (
    input  trigger, arm_req, disarm_req, tamper,
    output siren, led, alarm_mem, arm_fail, state
  );
`else
  modport master (
    output trigger, arm_req, disarm_req,
    input  siren, led, alarm_mem, arm_fail, state
  );

  modport slave (
    input  trigger, arm_req, disarm_req,
    output siren, led, alarm_mem, arm_fail, state
  );
`endif
endinterface

// File: rtl/alarm_siren_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_siren_ctrl
//   Sequential back end of the alarm path. Takes the voter's majority flag as
//   `trigger` and adds arm/disarm control, an exit delay, an entry delay, a
//   timed siren, an alarm-memory latch and a status LED.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset; silences the siren immediately
//     bus    alarm_siren_ctrl_if.slave
//              in : trigger, arm_req, disarm_req (, tamper)
//              out: siren, led, alarm_mem, arm_fail, state[2:0]
//
//   Parameters:
//     EXIT_DELAY   cycles from accepted arm to ARMED            (>=1)
//     ENTRY_DELAY  cycles from trigger in ARMED to ALARM         (>=1)
//     SIREN_TIME   cycles the siren stays on per alarm event     (>=1)
//     BLINK_DIV    LED blink half-period in cycles               (>=1)
//
//   State codes: DISARMED=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4 HOLD=5;
//   codes 6/7 fall back to DISARMED on the next edge.
//
//   Optional feature macro: TAMPER_EN. When defined, bus.tamper=1 forces
//   ALARM from any state with a fresh siren period, overrides disarm_req,
//   and sets alarm_mem.
//
//   All outputs are registered and are computed from the next state, so they
//   change on the same edge as the state.
// -----------------------------------------------------------------------------
module alarm_siren_ctrl #(
  parameter int EXIT_DELAY  = 16,
  parameter int ENTRY_DELAY = 8,
  parameter int SIREN_TIME  = 64,
  parameter int BLINK_DIV   = 4
) (
  input logic               clk,
  input logic               rst_n,
  alarm_siren_ctrl_if.slave bus
);

  localparam int MAX_ED    = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int MAX_DELAY = (MAX_ED > SIREN_TIME) ? MAX_ED : SIREN_TIME;
  localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int PRE_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  // Delay counter never wraps below zero.
  function automatic logic [CNT_W-1:0] cnt_dec_sat(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  // Blink prescaler counts 0..BLINK_DIV-1 and wraps.
  function automatic logic [PRE_W-1:0] presc_inc_wrap(input logic [PRE_W-1:0] p);
    return (p == PRE_MAX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic is_blink(input state_t s);
    return (s == S_EXIT) || (s == S_ENTRY) || (s == S_HOLD);
  endfunction

  state_t           state_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [PRE_W-1:0] presc_p1;
  logic             siren_p1;
  logic             led_p1;
  logic             mem_p1;
  logic             arm_fail_p1;

  state_t           state_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [PRE_W-1:0] presc_p0;
  logic             siren_p0;
  logic             led_p0;
  logic             mem_p0;
  logic             arm_fail_p0;
  logic             cnt_zero;
  logic             tamper_hit;

  assign cnt_zero = (cnt_p1 == '0);

`ifdef TAMPER_EN
  assign tamper_hit = bus.tamper;
`else
  assign tamper_hit = 1'b0;
`endif

  // ---- stage p0: next-state and next-output decode ----
  always_comb begin
    state_p0    = S_DISARMED;
    cnt_p0      = cnt_dec_sat(cnt_p1);
    mem_p0      = mem_p1;
    arm_fail_p0 = 1'b0;

    case (state_p1)
      S_DISARMED: begin
        state_p0 = S_DISARMED;
        // disarm_req is a no-op here, so arm is evaluated even if both are set.
        if (bus.arm_req) begin
          if (bus.trigger) begin
            arm_fail_p0 = 1'b1;
          end else begin
            state_p0 = S_EXIT;
            cnt_p0   = EXIT_LOAD;
            mem_p0   = 1'b0;
          end
        end
      end

      S_EXIT: begin
        if (bus.disarm_req)  state_p0 = S_DISARMED;
        else if (cnt_zero)   state_p0 = S_ARMED;
        else                 state_p0 = S_EXIT;
      end

      S_ARMED: begin
        if (bus.disarm_req) begin
          state_p0 = S_DISARMED;
        end else if (bus.trigger) begin
          state_p0 = S_ENTRY;
          cnt_p0   = ENTRY_LOAD;
        end else begin
          state_p0 = S_ARMED;
        end
      end

      S_ENTRY: begin
        // A trigger that drops during the entry delay does not abort it.
        if (bus.disarm_req) begin
          state_p0 = S_DISARMED;
        end else if (cnt_zero) begin
          state_p0 = S_ALARM;
          cnt_p0   = SIREN_LOAD;
          mem_p0   = 1'b1;
        end else begin
          state_p0 = S_ENTRY;
        end
      end

      S_ALARM: begin
        if (bus.disarm_req)  state_p0 = S_DISARMED;
        else if (cnt_zero)   state_p0 = S_HOLD;
        else                 state_p0 = S_ALARM;
      end

      S_HOLD: begin
        // Re-trigger goes straight back to the siren, no entry delay.
        if (bus.disarm_req) begin
          state_p0 = S_DISARMED;
        end else if (bus.trigger) begin
          state_p0 = S_ALARM;
          cnt_p0   = SIREN_LOAD;
          mem_p0   = 1'b1;
        end else begin
          state_p0 = S_HOLD;
        end
      end

      default: begin
        state_p0 = S_DISARMED;
      end
    endcase

    // Tamper outranks everything, including disarm and an arm attempt.
    if (tamper_hit) begin
      state_p0    = S_ALARM;
      cnt_p0      = SIREN_LOAD;
      mem_p0      = 1'b1;
      arm_fail_p0 = 1'b0;
    end
  end

  always_comb begin
    presc_p0 = presc_inc_wrap(presc_p1);
    siren_p0 = (state_p0 == S_ALARM);
    led_p0   = 1'b0;

    if (is_blink(state_p0)) begin
      if (state_p0 != state_p1) begin
        // Fresh entry into a blink state starts the phase with LED on.
        presc_p0 = '0;
        led_p0   = 1'b1;
      end else if (presc_p1 == PRE_MAX) begin
        led_p0 = ~led_p1;
      end else begin
        led_p0 = led_p1;
      end
    end else begin
      led_p0 = (state_p0 == S_ARMED) || (state_p0 == S_ALARM);
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= S_DISARMED;
      cnt_p1      <= '0;
      presc_p1    <= '0;
      siren_p1    <= 1'b0;
      led_p1      <= 1'b0;
      mem_p1      <= 1'b0;
      arm_fail_p1 <= 1'b0;
    end else begin
      state_p1    <= state_p0;
      cnt_p1      <= cnt_p0;
      presc_p1    <= presc_p0;
      siren_p1    <= siren_p0;
      led_p1      <= led_p0;
      mem_p1      <= mem_p0;
      arm_fail_p1 <= arm_fail_p0;
    end
  end

  assign bus.state     = state_p1;
  assign bus.siren     = siren_p1;
  assign bus.led       = led_p1;
  assign bus.alarm_mem = mem_p1;
  assign bus.arm_fail  = arm_fail_p1;

endmodule
